// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: DUT-side endpoint of the remote command link.
// Receives 16-bit commands as two UART bytes (high byte first) and sends
// 8-bit responses back. Contains its own receiver, transmitter and the
// two-state byte-assembly FSM.
//
// Optional feature: define UART_CMD_TIMEOUT_EN to build an inter-byte
// timeout that abandons a half-received command after TIMEOUT_CLKS clocks.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for the high byte of the next command
// ST_LOW  | high byte stored, waiting for the low byte
module uart_cmd_wrapper #(
    parameter int BAUD_DIV     = 2604,
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam int            BW        = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);

    // Parameter sanity check at elaboration
    if (BAUD_DIV < 4 || TIMEOUT_CLKS < 1) begin : g_bad_params
        $error("uart_cmd_wrapper: BAUD_DIV must be >= 4 and TIMEOUT_CLKS >= 1");
    end

    typedef enum logic {ST_IDLE, ST_LOW} state_t;

    logic          rx_meta, rx_sync, rx_prev;
    logic          rx_busy;
    logic [BW-1:0] rx_cnt;
    logic [3:0]    rx_idx;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_byte;
    logic          rx_strobe;

    logic          tx_busy;
    logic [BW-1:0] tx_cnt;
    logic [3:0]    tx_idx;
    logic [8:0]    tx_shift;

    state_t        state, state_nxt;
    logic          load_high, load_cmd;
    logic          timeout_hit;
    logic [7:0]    high_byte;

    // Two-flop synchronizer for RX plus a history flop for start-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver: half-bit first delay, then sample every bit center; strobe valid bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy   <= 1'b0;
            rx_cnt    <= '0;
            rx_idx    <= '0;
            rx_shift  <= '0;
            rx_byte   <= '0;
            rx_strobe <= 1'b0;
        end else begin
            rx_strobe <= 1'b0;
            if (!rx_busy) begin
                if (rx_prev && !rx_sync) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= BAUD_HALF;
                    rx_idx  <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - BW'(1);
            end else begin
                rx_cnt <= BAUD_LAST;
                rx_idx <= rx_idx + 4'd1;
                if (rx_idx == 4'd0) begin
                    // start bit high at its center: treat as a glitch
                    if (rx_sync) rx_busy <= 1'b0;
                end else if (rx_idx == 4'd9) begin
                    rx_busy <= 1'b0;
                    // a low stop bit drops the byte silently
                    if (rx_sync) begin
                        rx_byte   <= rx_shift;
                        rx_strobe <= 1'b1;
                    end
                end else begin
                    rx_shift <= {rx_sync, rx_shift[7:1]};
                end
            end
        end
    end

    // Transmitter: start bit driven on acceptance, then data LSB first and stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            TX       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '1;
            tx_done  <= 1'b0;
        end else if (!tx_busy) begin
            if (trmt) begin
                TX       <= 1'b0;
                tx_shift <= {1'b1, resp};
                tx_busy  <= 1'b1;
                tx_cnt   <= BAUD_LAST;
                tx_idx   <= '0;
                tx_done  <= 1'b0;
            end
        end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - BW'(1);
        end else if (tx_idx == 4'd9) begin
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
        end else begin
            TX       <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[8:1]};
            tx_cnt   <= BAUD_LAST;
            tx_idx   <= tx_idx + 4'd1;
        end
    end

`ifdef UART_CMD_TIMEOUT_EN
    logic [31:0] to_cnt;

    // Inter-byte timer: rearmed by every strobe, terminal count ends the LOW wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (rx_strobe) begin
            to_cnt <= 32'(TIMEOUT_CLKS - 1);
        end else if (state == ST_LOW && to_cnt != '0) begin
            to_cnt <= to_cnt - 32'd1;
        end
    end

    assign timeout_hit = (to_cnt == '0);
`else
    assign timeout_hit = 1'b0;
`endif

    // Assembly FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Assembly FSM next-state and load controls
    always_comb begin
        state_nxt = state;
        load_high = 1'b0;
        load_cmd  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_strobe) begin
                    load_high = 1'b1;
                    state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                if (rx_strobe) begin
                    load_cmd  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (timeout_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command registers: cmd only moves on completion; completion beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_byte <= '0;
            cmd       <= '0;
            cmd_rdy   <= 1'b0;
        end else begin
            if (load_high) high_byte <= rx_byte;
            if (load_cmd)  cmd <= {high_byte, rx_byte};
            if (load_cmd)                        cmd_rdy <= 1'b1;
            else if (load_high || clr_cmd_rdy)   cmd_rdy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Testbench for uart_cmd_wrapper: directed scenarios plus randomized
// full-duplex traffic, checked every cycle against a behavioural model
// (byte-event command assembly and a timeline view of the TX frame).
`timescale 1ns/1ps
module tb_uart_cmd_wrapper;

    localparam int B  = 16;
    localparam int TO = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        trmt = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        tx_done;

    uart_cmd_wrapper #(.BAUD_DIV(B), .TIMEOUT_CLKS(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .trmt        (trmt),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    logic [15:0] m_cmd = 16'h0000;
    logic        m_rdy = 1'b0;
    logic        m_pend = 1'b0;
    logic [7:0]  m_high = 8'h00;
    int          m_high_cyc = 0;
    logic        m_tx_started = 1'b0;
    int          m_tx_e0 = 0;
    logic [7:0]  m_tx_byte = 8'h00;

    logic        settle = 1'b0;
    int          last_start = 0;
    int          rise_cyc = -1;
    logic        rx_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_cmd = 16'h0000;
        m_rdy = 1'b0;
        m_pend = 1'b0;
        m_tx_started = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
`ifdef UART_CMD_TIMEOUT_EN
        if (m_pend && (cyc - m_high_cyc) >= TO) m_pend = 1'b0;
`endif
        if (!m_pend) begin
            m_high = b;
            m_pend = 1'b1;
            m_rdy = 1'b0;
            m_high_cyc = cyc;
        end else begin
            m_cmd = {m_high, b};
            m_rdy = 1'b1;
            m_pend = 1'b0;
        end
    endtask

    // called at a negedge; drives nbits of the frame, each B clocks long
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        last_start = cyc;
        for (int k = 0; k < nbits; k++) begin
            RX = fr[k];
            if (k == 9) settle = 1'b1;
            repeat (B) @(negedge clk);
        end
        RX = 1'b1;
        if (nbits == 10 && stop_bit) model_byte(b);
        settle = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        m_rdy = 1'b0;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic send_trmt(input logic [7:0] r);
        resp = r;
        trmt = 1'b1;
        if (!m_tx_started || (cyc + 1 - m_tx_e0) > 10 * B) begin
            m_tx_started = 1'b1;
            m_tx_e0 = cyc + 1;
            m_tx_byte = r;
        end
        @(negedge clk);
        trmt = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        RX = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Every-cycle comparison of DUT outputs against the model
    initial begin : compare
        logic       prev_rdy;
        int         el;
        logic [9:0] fr;
        logic       etx, edone;
        prev_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cmd_rdy === 1'b1 && prev_rdy === 1'b0) rise_cyc = cyc;
            prev_rdy = cmd_rdy;
            if (!settle) begin
                check("cmd", 32'(cmd), 32'(m_cmd));
                check("cmd_rdy", 32'(cmd_rdy), 32'(m_rdy));
            end
            etx = 1'b1;
            edone = 1'b0;
            if (m_tx_started) begin
                el = cyc - m_tx_e0;
                fr = {1'b1, m_tx_byte, 1'b0};
                if (el >= 10 * B) edone = 1'b1;
                else if (el >= 0) etx = fr[el / B];
            end
            check("TX", 32'(TX), 32'(etx));
            check("tx_done", 32'(tx_done), 32'(edone));
        end
    end

    initial begin : main
        int         lat, s, e0;
        logic [15:0] c;
        logic [9:0] a5_bits;
        a5_bits = 10'b1101001010;

        // 1: reset values, idle line does nothing
        repeat (3) @(negedge clk);
        check("rst_TX", 32'(TX), 32'd1);
        check("rst_cmd", 32'(cmd), 32'h0000);
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("idle_cmd_rdy", 32'(cmd_rdy), 32'd0);

        // 2: command 0x7000, latency, clear
        send_frame(8'h70, 1'b1, 10);
        repeat (5) @(negedge clk);
        send_frame(8'h00, 1'b1, 10);
        lat = rise_cyc - last_start;
        check("rdy_latency_window", 32'(lat >= (19 * B) / 2 + 1 && lat <= (19 * B) / 2 + 7), 32'd1);
        check("cmd_7000", 32'(cmd), 32'h7000);
        check("rdy_7000", 32'(cmd_rdy), 32'd1);
        pulse_clr();
        check("rdy_after_clr", 32'(cmd_rdy), 32'd0);
        check("cmd_after_clr", 32'(cmd), 32'h7000);

        // 3: transmit 0xA5, bit centers, ignored mid-frame trmt, tx_done timing
        s = cyc;
        send_trmt(8'hA5);
        e0 = s + 1;
        check("tx_fall", 32'(TX), 32'd0);
        for (int k = 0; k < 10; k++) begin
            while (cyc < e0 + k * B + B / 2) @(negedge clk);
            check("tx_a5_bit", 32'(TX), 32'(a5_bits[k]));
            if (k == 4) send_trmt(8'h00);
        end
        while (cyc < e0 + 10 * B - 1) @(negedge clk);
        check("tx_done_early", 32'(tx_done), 32'd0);
        @(negedge clk);
        check("tx_done_exact", 32'(tx_done), 32'd1);
        repeat (10) @(negedge clk);

        // 4: back-to-back without clear, clear in completion cycle
        send_frame(8'h20, 1'b1, 10);
        send_frame(8'h00, 1'b1, 10);
        check("cmd_2000", 32'(cmd), 32'h2000);
        check("rdy_2000", 32'(cmd_rdy), 32'd1);
        send_frame(8'h5B, 1'b1, 10);
        check("rdy_drop_5b", 32'(cmd_rdy), 32'd0);
        check("cmd_hold_2000", 32'(cmd), 32'h2000);
        fork
            send_frame(8'hEF, 1'b1, 10);
            begin
                repeat (lat - 1) @(negedge clk);
                pulse_clr();
            end
        join
        check("cmd_5bef", 32'(cmd), 32'h5BEF);
        check("set_beats_clr", 32'(cmd_rdy), 32'd1);

        // 5: lone high byte, long idle, then 0x12 0x34
        send_frame(8'h41, 1'b1, 10);
        repeat (2 * TO) @(negedge clk);
        send_frame(8'h12, 1'b1, 10);
        send_frame(8'h34, 1'b1, 10);
`ifdef UART_CMD_TIMEOUT_EN
        check("timeout_cmd", 32'(cmd), 32'h1234);
`else
        check("no_timeout_cmd", 32'(cmd), 32'h4112);
`endif

        // 6: framing error (0x34 still pending), reset mid low byte, then 0x6123
        send_frame(8'h55, 1'b0, 10);
        repeat (2 * B) @(negedge clk);
        check("framing_no_cmd_rdy", 32'(cmd_rdy), 32'd0);
        send_frame(8'h77, 1'b1, 5);
        do_reset();
        check("midreset_cmd", 32'(cmd), 32'h0000);
        check("midreset_rdy", 32'(cmd_rdy), 32'd0);
        repeat (12 * B) @(negedge clk);
        send_frame(8'h61, 1'b1, 10);
        send_frame(8'h23, 1'b1, 10);
        check("cmd_6123", 32'(cmd), 32'h6123);

        // 7: randomized full-duplex traffic
        rx_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    c = 16'($urandom);
                    send_frame(c[15:8], 1'b1, 10);
                    repeat ($urandom_range(0, 20)) @(negedge clk);
                    if ($urandom_range(0, 1) == 1) pulse_clr();
                    send_frame(c[7:0], 1'b1, 10);
                    repeat ($urandom_range(1, 10)) @(negedge clk);
                    if ($urandom_range(0, 1) == 1) pulse_clr();
                end
                rx_done = 1'b1;
            end
            begin
                while (!rx_done) begin
                    repeat ($urandom_range(1, 60)) @(negedge clk);
                    send_trmt(8'($urandom_range(0, 255)));
                end
            end
        join
        repeat (12 * B) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
